// File: rtl/ucsbece154a_datapath_mc.sv
// Multicycle RV32I datapath: PC/OldPC/IR/Data/A/B/ALUOut, 32x32 register file, unified memory port.
// Optional macro DATAPATH_MISALIGN_TRAP_EN: blocks misaligned PC loads and raises sticky misalign_o.
module ucsbece154a_datapath_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          PCWrite_i,
  input  logic          AdrSrc_i,
  input  logic          IRWrite_i,
  input  logic          RegWrite_i,
  input  logic [1:0]    ALUSrcA_i,
  input  logic [1:0]    ALUSrcB_i,
  input  logic [1:0]    ResultSrc_i,
  input  logic [2:0]    ALUControl_i,
  input  logic [2:0]    ImmSrc_i,
  input  logic [DW-1:0] ReadData_i,
  output logic [DW-1:0] Adr_o,
  output logic [DW-1:0] WriteData_o,
  output logic [6:0]    op_o,
  output logic [2:0]    funct3_o,
  output logic          funct7_o,
  output logic          zero_o
`ifdef DATAPATH_MISALIGN_TRAP_EN
  ,
  output logic          misalign_o
`endif
);

  logic [DW-1:0] r_pc, r_oldpc, r_ir, r_data, r_a, r_b, r_aluout;
  logic [DW-1:0] r_rf [32];
  logic [DW-1:0] w_imm, w_srca, w_srcb, w_alu, w_result, w_rf1, w_rf2;
  logic [4:0]    w_rs1, w_rs2, w_rd;
  logic          w_pc_load;

  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_rd  = r_ir[11:7];

  always_comb begin
    w_imm = '0;
    case (ImmSrc_i)
      3'b000:  w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
      3'b001:  w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      3'b010:  w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      3'b011:  w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      3'b100:  w_imm = {r_ir[31:12], 12'b0};
      default: w_imm = '0;
    endcase
  end

  always_comb begin
    w_srca = '0;
    case (ALUSrcA_i)
      2'b00:   w_srca = r_pc;
      2'b01:   w_srca = r_oldpc;
      2'b10:   w_srca = r_a;
      default: w_srca = '0;
    endcase
  end

  always_comb begin
    w_srcb = '0;
    case (ALUSrcB_i)
      2'b00:   w_srcb = r_b;
      2'b01:   w_srcb = w_imm;
      2'b10:   w_srcb = 32'd4;
      default: w_srcb = '0;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (ALUControl_i)
      3'b000:  w_alu = w_srca + w_srcb;
      3'b001:  w_alu = w_srca - w_srcb;
      3'b010:  w_alu = w_srca & w_srcb;
      3'b011:  w_alu = w_srca | w_srcb;
      3'b101:  w_alu = {{(DW-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (ResultSrc_i)
      2'b00:   w_result = r_aluout;
      2'b01:   w_result = r_data;
      2'b10:   w_result = w_alu;
      default: w_result = w_imm;
    endcase
  end

  // x0 is never written, but the read guard keeps it hard-wired to zero
  assign w_rf1 = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
  assign w_rf2 = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (RegWrite_i && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= w_result;
    end
  end

`ifdef DATAPATH_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_pc_load = PCWrite_i && (w_result[1:0] == 2'b00);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_misalign <= 1'b0;
    else if (PCWrite_i && (w_result[1:0] != 2'b00)) r_misalign <= 1'b1;
  end
  assign misalign_o = r_misalign;
`else
  assign w_pc_load = PCWrite_i;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_oldpc  <= '0;
      r_ir     <= '0;
      r_data   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      r_data   <= ReadData_i;
      r_a      <= w_rf1;
      r_b      <= w_rf2;
      r_aluout <= w_alu;
      if (IRWrite_i) begin
        r_ir    <= ReadData_i;
        r_oldpc <= r_pc;
      end
      if (w_pc_load) r_pc <= w_result;
    end
  end

  assign Adr_o       = AdrSrc_i ? w_result : r_pc;
  assign WriteData_o = r_b;
  assign op_o        = r_ir[6:0];
  assign funct3_o    = r_ir[14:12];
  assign funct7_o    = r_ir[30];
  assign zero_o      = (w_alu == '0);

endmodule

// File: tb/tb_ucsbece154a_datapath_mc.sv
// Bench for ucsbece154a_datapath_mc: architectural model compared every cycle, directed
// instruction sequences with literal expectations, then randomized strobes with async resets.
module tb_ucsbece154a_datapath_mc;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCWrite_i = 1'b0, AdrSrc_i = 1'b0, IRWrite_i = 1'b0, RegWrite_i = 1'b0;
  logic [1:0]  ALUSrcA_i = '0, ALUSrcB_i = '0, ResultSrc_i = '0;
  logic [2:0]  ALUControl_i = '0, ImmSrc_i = '0;
  logic [31:0] ReadData_i = '0;
  logic [31:0] Adr_o, WriteData_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7_o, zero_o;
`ifdef DATAPATH_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  ucsbece154a_datapath_mc #(.RESET_PC(RPC), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .PCWrite_i(PCWrite_i), .AdrSrc_i(AdrSrc_i), .IRWrite_i(IRWrite_i), .RegWrite_i(RegWrite_i),
    .ALUSrcA_i(ALUSrcA_i), .ALUSrcB_i(ALUSrcB_i), .ResultSrc_i(ResultSrc_i),
    .ALUControl_i(ALUControl_i), .ImmSrc_i(ImmSrc_i), .ReadData_i(ReadData_i),
    .Adr_o(Adr_o), .WriteData_o(WriteData_o), .op_o(op_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .zero_o(zero_o)
`ifdef DATAPATH_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  // architectural state of the model
  logic [31:0] m_pc, m_oldpc, m_ir, m_data, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];
  logic        m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] sx(input longint f, input int n);
    longint v;
    v = f;
    if (v >= (64'sd1 <<< (n - 1))) v = v - (64'sd1 <<< n);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_imm();
    longint ir;
    ir = longint'(m_ir);
    case (ImmSrc_i)
      3'd0: return sx(ir >> 20, 12);
      3'd1: return sx((ir >> 25) * 32 + ((ir >> 7) & 31), 12);
      3'd2: return sx(((ir >> 31) & 1) * 4096 + ((ir >> 7) & 1) * 2048
                      + ((ir >> 25) & 63) * 32 + ((ir >> 8) & 15) * 2, 13);
      3'd3: return sx(((ir >> 31) & 1) * 1048576 + ((ir >> 12) & 255) * 4096
                      + ((ir >> 20) & 1) * 2048 + ((ir >> 21) & 1023) * 2, 21);
      3'd4: return m_ir & 32'hFFFF_F000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_alu();
    logic [31:0] a, b;
    case (ALUSrcA_i)
      2'd0: a = m_pc;
      2'd1: a = m_oldpc;
      2'd2: a = m_a;
      default: a = 32'd0;
    endcase
    case (ALUSrcB_i)
      2'd0: b = m_b;
      2'd1: b = m_imm();
      2'd2: b = 32'd4;
      default: b = 32'd0;
    endcase
    case (ALUControl_i)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    case (ResultSrc_i)
      2'd0: return m_aluout;
      2'd1: return m_data;
      2'd2: return m_alu();
      default: return m_imm();
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_oldpc = 0; m_ir = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0; m_mis = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] res, alu, ra, rb;
    int rd;
    if (reset) begin
      model_reset();
    end else begin
      res = m_result();
      alu = m_alu();
      ra  = m_rf[m_ir[19:15]];
      rb  = m_rf[m_ir[24:20]];
      rd  = int'(m_ir[11:7]);
      if (RegWrite_i && rd != 0) m_rf[rd] = res;
      m_data = ReadData_i; m_a = ra; m_b = rb; m_aluout = alu;
      if (IRWrite_i) begin m_oldpc = m_pc; m_ir = ReadData_i; end
`ifdef DATAPATH_MISALIGN_TRAP_EN
      if (PCWrite_i && res[1:0] != 2'b00) m_mis = 1'b1;
      else if (PCWrite_i) m_pc = res;
`else
      if (PCWrite_i) m_pc = res;
`endif
    end
  endtask

  task automatic compare_all();
    check("adr", Adr_o, AdrSrc_i ? m_result() : m_pc);
    check("wdata", WriteData_o, m_b);
    check("op", 32'(op_o), 32'(m_ir[6:0]));
    check("funct3", 32'(funct3_o), 32'(m_ir[14:12]));
    check("funct7", 32'(funct7_o), 32'(m_ir[30]));
    check("zero", 32'(zero_o), (m_alu() == 32'd0) ? 32'd1 : 32'd0);
`ifdef DATAPATH_MISALIGN_TRAP_EN
    check("misalign", 32'(misalign_o), 32'(m_mis));
`endif
  endtask

  // compare at the falling edge, advance the model on the rising edge, return just after it
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic pcw, input logic adr, input logic irw, input logic regw,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                       input logic [2:0] ac, input logic [2:0] is, input logic [31:0] rdata);
    PCWrite_i = pcw; AdrSrc_i = adr; IRWrite_i = irw; RegWrite_i = regw;
    ALUSrcA_i = sa; ALUSrcB_i = sb; ResultSrc_i = rs;
    ALUControl_i = ac; ImmSrc_i = is; ReadData_i = rdata;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 32'd0);
  endtask

  task automatic fetch_ir(input logic [31:0] instr);
    drive(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, instr);
    tick();
  endtask

  // load value through the Data register and write it back to rd
  task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
    fetch_ir({12'h000, 5'd0, 3'b000, r, 7'h03});
    drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, v);
    tick();
    drive(0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 32'd0);
    tick();
  endtask

  task automatic rd_reg(input logic [4:0] r, input logic [31:0] exp, input string name);
    fetch_ir({7'h00, r, r, 3'b000, 5'd0, 7'h33});
    idle();
    tick();
    check(name, WriteData_o, exp);
  endtask

  initial begin
    idle();
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_pc", Adr_o, 32'h0000_0100);
    check("async_reset_op", 32'(op_o), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Fetch: IR <= mem, OldPC <= PC, PC <= PC+4
    drive(1, 0, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 32'h0050_0093);
    tick();
    check("fetch_op", 32'(op_o), 32'h13);
    check("fetch_pc", Adr_o, 32'h0000_0104);
    drive(0, 1, 0, 0, 2'b01, 2'b11, 2'b10, 3'b000, 3'b000, 32'd0);
    #1;
    check("fetch_oldpc", Adr_o, 32'h0000_0100);

    // addi x1,x0,5: Decode, ExecuteI, ALUWB
    idle(); tick();
    drive(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 32'd0); tick();
    drive(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 32'd0); tick();
    rd_reg(5'd1, 32'd5, "addi_x1");

    // addi x0,x0,7 must leave x0 at zero
    fetch_ir(32'h0070_0013);
    drive(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 32'd0); tick();
    drive(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 32'd0); tick();
    rd_reg(5'd0, 32'd0, "x0_hardwired");

    // sub x4,x1,x2 with equal operands
    wr_reg(5'd1, 32'd3);
    wr_reg(5'd2, 32'd3);
    fetch_ir({7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'h33});
    idle(); tick();
    drive(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000, 32'd0);
    #1;
    check("sub_zero", 32'(zero_o), 32'd1);
    check("sub_funct7", 32'(funct7_o), 32'd1);
    drive(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 32'd0);
    #1;
    check("add_nonzero", 32'(zero_o), 32'd0);

    // slt x4,x1,x2 with -1 < 1
    wr_reg(5'd1, 32'hFFFF_FFFF);
    wr_reg(5'd2, 32'd1);
    fetch_ir({7'h00, 5'd2, 5'd1, 3'b010, 5'd4, 7'h33});
    idle(); tick();
    drive(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b101, 3'b000, 32'd0); tick();
    drive(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 32'd0);
    #1;
    check("slt_aluout", Adr_o, 32'd1);
    check("slt_funct3", 32'(funct3_o), 32'd2);

    // lui x5,0x12345 and jal immediate
    fetch_ir(32'h1234_52B7);
    drive(0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 3'b000, 3'b100, 32'd0); tick();
    rd_reg(5'd5, 32'h1234_5000, "lui_x5");
    fetch_ir(32'h0080_006F);
    drive(0, 1, 0, 0, 2'b00, 2'b00, 2'b11, 3'b000, 3'b011, 32'd0);
    #1;
    check("jal_imm", Adr_o, 32'd8);

    // sw x2,0x40(x0)
    wr_reg(5'd2, 32'hDEAD_BEEF);
    fetch_ir({7'b0000010, 5'd2, 5'd0, 3'b010, 5'd0, 7'h23});
    idle(); tick();
    drive(0, 1, 0, 0, 2'b11, 2'b01, 2'b10, 3'b000, 3'b001, 32'd0);
    #1;
    check("sw_adr", Adr_o, 32'h40);
    check("sw_wdata", WriteData_o, 32'hDEAD_BEEF);

    // lw x7,0x40(x0): MemRead then MemWB
    fetch_ir({12'h040, 5'd0, 3'b010, 5'd7, 7'h03});
    drive(0, 1, 0, 0, 2'b11, 2'b01, 2'b10, 3'b000, 3'b000, 32'hCAFE_F00D); tick();
    drive(0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 32'd0); tick();
    rd_reg(5'd7, 32'hCAFE_F00D, "lw_x7");

    // PC load of a misaligned target (PC was last written by the first fetch: 0x104)
    fetch_ir({12'h102, 5'd0, 3'b000, 5'd0, 7'h13});
    drive(1, 0, 0, 0, 2'b00, 2'b00, 2'b11, 3'b000, 3'b000, 32'd0); tick();
    idle();
    #1;
`ifdef DATAPATH_MISALIGN_TRAP_EN
    check("misalign_pc_held", Adr_o, 32'h0000_0104);
    check("misalign_set", 32'(misalign_o), 32'd1);
    tick(); tick(); tick();
    check("misalign_sticky", 32'(misalign_o), 32'd1);
`else
    check("misalign_pc_loaded", Adr_o, 32'h0000_0102);
`endif

    // randomized strobes, with occasional asynchronous reset mid-cycle
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
      end
      drive(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
